// File: rtl/loader_pkg.sv
// Shared types and defaults for the mem_loader boot-stream loader.
// The CHK state is present in the enum in every build; it is only reachable when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int unsigned AW_DEF         = 8;
  localparam int unsigned CW_DEF         = 16;
  localparam int unsigned MAX_CYCLES_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE,
    HDR_BASE,
    HDR_LEN,
    LOAD,
    CHK,
    RUN,
    DONE,
    ERR
  } state_t;

  typedef logic [7:0] hdr_byte_t;
  typedef logic [8:0] load_len_t;

  // A length byte of zero encodes a full 256-byte payload.
  function automatic load_len_t decode_len(input hdr_byte_t b);
    return (b == 8'd0) ? 9'd256 : {1'b0, b};
  endfunction

endpackage

// File: rtl/run_timer.sv
// Run-length counter for the loaded core; expired flags when the count reaches MAX_CYCLES.
module run_timer #(
  parameter int unsigned CW         = 16,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          expired
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count   = r_count;
  assign expired = (r_count == CW'(MAX_CYCLES));

endmodule

// File: rtl/mem_loader.sv
// Streams a header (base, len) plus payload into data memory, then releases the core and times its run.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned CW         = CW_DEF,
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_dat,
  output logic          core_reset,
  input  logic          core_done,
  output logic          finished,
  output logic          err,
  output logic [CW-1:0] cycles
);

  state_t        r_state;
  state_t        w_next;
  hdr_byte_t     r_base;
  load_len_t     r_len;
  load_len_t     r_idx;
  logic          r_wr_en;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_dat;
  logic          w_xfer;
  logic          w_last;
  logic          w_start_ok;
  logic          w_expired;
  logic          w_tmr_en;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    r_sum;
`endif

  assign w_xfer     = in_valid && in_ready;
  assign w_last     = (r_idx == r_len - 9'd1);
  assign w_start_ok = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_tmr_en   = (r_state == RUN) && !core_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    core_reset = 1'b1;
    finished   = 1'b0;
    err        = 1'b0;
    case (r_state)
      IDLE, DONE, ERR: begin
        finished = (r_state == DONE);
        err      = (r_state == ERR);
        if (start) w_next = HDR_BASE;
      end
      HDR_BASE: begin
        in_ready = 1'b1;
        if (w_xfer) w_next = HDR_LEN;
      end
      HDR_LEN: begin
        in_ready = 1'b1;
        if (w_xfer) w_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (w_xfer && w_last) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = CHK;
`else
          w_next = RUN;
`endif
        end
      end
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        if (w_xfer) w_next = (in_data == r_sum) ? RUN : ERR;
`else
        w_next = IDLE;
`endif
      end
      RUN: begin
        core_reset = 1'b0;
        // Done wins over a simultaneous timeout.
        if (core_done)      w_next = DONE;
        else if (w_expired) w_next = ERR;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_dat   <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          HDR_BASE: r_base <= in_data;
          HDR_LEN: begin
            r_len <= decode_len(in_data);
            r_idx <= '0;
          end
          LOAD: begin
            r_wr_en <= 1'b1;
            r_addr  <= AW'(r_base) + AW'(r_idx);
            r_dat   <= in_data;
            r_idx   <= r_idx + 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum <= '0;
    end else if (w_xfer) begin
      if (r_state == HDR_BASE) r_sum <= in_data;
      else if (r_state == HDR_LEN || r_state == LOAD) r_sum <= r_sum + in_data;
    end
  end
`endif

  run_timer #(
    .CW        (CW),
    .MAX_CYCLES(MAX_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_start_ok),
    .en     (w_tmr_en),
    .count  (cycles),
    .expired(w_expired)
  );

  assign mem_wr_en = r_wr_en;
  assign mem_addr  = r_addr;
  assign mem_dat   = r_dat;

endmodule
